// File: rtl/loop_mon_pkg.sv
// ---------------------------------------------------------------------------
// loop_mon_pkg
// Shared types for the loop oscillation monitor: the FSM state encoding and
// the run-classification (res_kind) encoding, plus a helper that maps a
// settled tap value onto its stable classification.
// ---------------------------------------------------------------------------
package loop_mon_pkg;

    // Monitor control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // Run classification; 2'b11 is reserved and never produced
    typedef enum logic [1:0] {
        KIND_STABLE0 = 2'b00,
        KIND_STABLE1 = 2'b01,
        KIND_OSC     = 2'b10
    } kind_e;

    // A ring that did not oscillate is classified by where its tap settled
    function automatic kind_e stable_kind(input logic tap);
        return tap ? KIND_STABLE1 : KIND_STABLE0;
    endfunction

endpackage

// File: rtl/loop_ring.sv
// ---------------------------------------------------------------------------
// loop_ring
// Registered ring of STAGES single-bit stages. Each enabled cycle stage i
// loads (stage i-1 & pin_mask[i]), stage 0 taking the last stage; stage
// INV_POS is the single inverting (nand) stage. STAGES must be >= 3 and
// INV_POS must lie in 0..STAGES-1.
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   async active-low reset, clears all stages
//   i_load        in   load every stage with i_seed (wins over i_en)
//   i_seed        in   value loaded on i_load
//   i_en          in   advance the ring by one step
//   i_pin_mask    in   per-stage side gate input, used live
//   o_ring        out  current stage contents
//   o_next_tap_c  out  combinational value the tap would take on a step
// ---------------------------------------------------------------------------
module loop_ring #(
    parameter int unsigned STAGES  = 9,
    parameter int unsigned INV_POS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_seed,
    input  logic              i_en,
    input  logic [STAGES-1:0] i_pin_mask,
    output logic [STAGES-1:0] o_ring,
    output logic              o_next_tap_c
);

    // One-hot marker of the nand stage; xor with it turns its and into a nand
    localparam logic [STAGES-1:0] INV_MASK = STAGES'(1) << INV_POS;

    logic [STAGES-1:0] r_ring;
    logic [STAGES-1:0] w_prev;
    logic [STAGES-1:0] w_step;

    // Gate function for one ring step
    always_comb begin
        w_prev = {r_ring[STAGES-2:0], r_ring[STAGES-1]};
        w_step = (w_prev & i_pin_mask) ^ INV_MASK;
    end

    // Ring registers: load seed, step when enabled, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ring <= '0;
        end else if (i_load) begin
            r_ring <= {STAGES{i_seed}};
        end else if (i_en) begin
            r_ring <= w_step;
        end
    end

    assign o_ring       = r_ring;
    assign o_next_tap_c = w_step[STAGES-1];

endmodule

// File: rtl/loop_osc_monitor.sv
// ---------------------------------------------------------------------------
// loop_osc_monitor
// Runs a gated ring (loop_ring) from a seed and classifies the run as
// STABLE0 / STABLE1 / OSC by watching rising edges on the tap (last stage).
// The second rising edge ends the run as OSC with the cycle distance between
// the first two rises; otherwise the run ends when the cycle counter reaches
// the latched timeout and is classified by the tap value. The result is held
// in REPORT until accepted with a valid/ready handshake.
//
// Optional feature macro: LOOP_HIST_EN adds o_res_edges, the saturating count
// of all tap transitions during the run.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   async active-low reset
//   i_start        in   begin a run (only honoured in IDLE)
//   i_seed         in   value loaded into every ring stage on start
//   i_pin_mask     in   [STAGES] per-stage side gate inputs, live in RUN
//   i_timeout      in   [CNT_W] maximum observation cycles, latched on start
//   o_busy         out  high in RUN and REPORT
//   o_res_valid    out  result valid (REPORT)
//   i_res_ready    in   result accepted when high with o_res_valid
//   o_res_kind     out  [2] 00 STABLE0, 01 STABLE1, 10 OSC
//   o_res_period   out  [CNT_W] distance between first two rises, 0 if stable
//   o_res_edges    out  [CNT_W] tap transition count (LOOP_HIST_EN only)
//   o_ring_state   out  [STAGES] current ring contents
// ---------------------------------------------------------------------------
module loop_osc_monitor #(
    parameter int unsigned STAGES  = 9,
    parameter int unsigned INV_POS = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_seed,
    input  logic [STAGES-1:0] i_pin_mask,
    input  logic [CNT_W-1:0]  i_timeout,
    output logic              o_busy,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [1:0]        o_res_kind,
    output logic [CNT_W-1:0]  o_res_period,
`ifdef LOOP_HIST_EN
    output logic [CNT_W-1:0]  o_res_edges,
`endif
    output logic [STAGES-1:0] o_ring_state
);

    import loop_mon_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   r_first;
    logic [CNT_W-1:0]   w_first_nxt;
    logic               r_seen_rise;
    logic               w_seen_rise_nxt;
    logic [CNT_W-1:0]   r_timeout;
    logic [CNT_W-1:0]   w_timeout_nxt;
    logic [1:0]         r_kind;
    logic [1:0]         w_kind_nxt;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   w_period_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_valid;
    logic               w_valid_nxt;

    logic               w_load;
    logic               w_en;
    logic [STAGES-1:0]  w_ring;
    logic               w_tap;
    logic               w_next_tap;
    logic               w_rise;
    logic [CNT_W-1:0]   w_cnt_inc;

`ifdef LOOP_HIST_EN
    logic [CNT_W-1:0]   r_edges;
    logic [CNT_W-1:0]   w_edges_nxt;
    logic               w_toggle;
`endif

    loop_ring #(
        .STAGES  (STAGES),
        .INV_POS (INV_POS)
    ) u_ring (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_load),
        .i_seed       (i_seed),
        .i_en         (w_en),
        .i_pin_mask   (i_pin_mask),
        .o_ring       (w_ring),
        .o_next_tap_c (w_next_tap)
    );

    // Edges are judged between the tap now and the tap after this RUN step,
    // so the run can end on the very step that produces the deciding edge.
    always_comb begin
        w_tap     = w_ring[STAGES-1];
        w_rise    = ~w_tap & w_next_tap;
        w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end

    // Next-state and register-input logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_first_nxt     = r_first;
        w_seen_rise_nxt = r_seen_rise;
        w_timeout_nxt   = r_timeout;
        w_kind_nxt      = r_kind;
        w_period_nxt    = r_period;
        w_load          = 1'b0;
        w_en            = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_load          = 1'b1;
                    w_cnt_nxt       = '0;
                    w_first_nxt     = '0;
                    w_seen_rise_nxt = 1'b0;
                    w_timeout_nxt   = i_timeout;
                    w_kind_nxt      = KIND_STABLE0;
                    w_period_nxt    = '0;
                    w_state_nxt     = ST_RUN;
                end
            end

            ST_RUN: begin
                w_en      = 1'b1;
                w_cnt_nxt = w_cnt_inc;
                if (w_rise && r_seen_rise) begin
                    // Second rise takes priority over a coincident timeout
                    w_kind_nxt   = KIND_OSC;
                    w_period_nxt = w_cnt_inc - r_first;
                    w_state_nxt  = ST_REPORT;
                end else begin
                    if (w_rise) begin
                        w_seen_rise_nxt = 1'b1;
                        w_first_nxt     = w_cnt_inc;
                    end
                    // The first step already counts as 1, so timeout 0 ends after one step
                    if (w_cnt_inc >= r_timeout) begin
                        w_kind_nxt   = stable_kind(w_next_tap);
                        w_period_nxt = '0;
                        w_state_nxt  = ST_REPORT;
                    end
                end
            end

            ST_REPORT: begin
                if (i_res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_valid_nxt = (w_state_nxt == ST_REPORT);
    end

    // State and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_first     <= '0;
            r_seen_rise <= 1'b0;
            r_timeout   <= '0;
            r_kind      <= '0;
            r_period    <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_first     <= w_first_nxt;
            r_seen_rise <= w_seen_rise_nxt;
            r_timeout   <= w_timeout_nxt;
            r_kind      <= w_kind_nxt;
            r_period    <= w_period_nxt;
            r_busy      <= w_busy_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

`ifdef LOOP_HIST_EN
    // Saturating count of every tap transition seen during the run
    always_comb begin
        w_toggle    = w_tap ^ w_next_tap;
        w_edges_nxt = r_edges;
        if ((r_state == ST_IDLE) && i_start) begin
            w_edges_nxt = '0;
        end else if ((r_state == ST_RUN) && w_toggle && (r_edges != CNT_MAX)) begin
            w_edges_nxt = r_edges + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edges <= '0;
        end else begin
            r_edges <= w_edges_nxt;
        end
    end

    assign o_res_edges = r_edges;
`endif

    assign o_busy       = r_busy;
    assign o_res_valid  = r_valid;
    assign o_res_kind   = r_kind;
    assign o_res_period = r_period;
    assign o_ring_state = w_ring;

endmodule

// File: tb/tb_loop_osc_monitor.sv
// ---------------------------------------------------------------------------
// tb_loop_osc_monitor
// Directed vector table plus randomized runs against a reference model that
// steps the ring from its gate rules and classifies the run from the tap
// history. Honours LOOP_HIST_EN for the edge-count output.
// ---------------------------------------------------------------------------
module tb_loop_osc_monitor;

    localparam int unsigned S     = 9;
    localparam int unsigned INV   = 4;
    localparam int unsigned CW    = 8;

    logic          clk;
    logic          rst_n;
    logic          i_start;
    logic          i_seed;
    logic [S-1:0]  i_pin_mask;
    logic [CW-1:0] i_timeout;
    logic          o_busy;
    logic          o_res_valid;
    logic          i_res_ready;
    logic [1:0]    o_res_kind;
    logic [CW-1:0] o_res_period;
    logic [CW-1:0] o_res_edges;
    logic [S-1:0]  o_ring_state;

    int n_tests;
    int n_fail;

    loop_osc_monitor #(
        .STAGES  (S),
        .INV_POS (INV),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_seed       (i_seed),
        .i_pin_mask   (i_pin_mask),
        .i_timeout    (i_timeout),
        .o_busy       (o_busy),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_res_kind   (o_res_kind),
        .o_res_period (o_res_period),
`ifdef LOOP_HIST_EN
        .o_res_edges  (o_res_edges),
`endif
        .o_ring_state (o_ring_state)
    );

`ifndef LOOP_HIST_EN
    assign o_res_edges = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         seed;
        logic [S-1:0] mask;
        int           tmo;
        int           kind;
        int           period;
        int           edges;
        int           len;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: step the ring by its gate rules, record the tap history and
    // classify from the positions of the rising edges.
    function automatic void model_run(input logic seed, input logic [S-1:0] mask, input int tmo,
                                      output int kind, output int period, output int edges,
                                      output int len, output logic [S-1:0] ring_end);
        logic [S-1:0] ring;
        logic [S-1:0] nx;
        int           taps[$];
        int           rises[$];
        int           t_end;
        int           p;
        logic         g;
        ring  = {S{seed}};
        taps.push_back(int'(seed));
        edges = 0;
        t_end = (tmo == 0) ? 1 : tmo;
        for (int n = 1; n <= t_end; n++) begin
            for (int i = 0; i < int'(S); i++) begin
                p = (i == 0) ? int'(S) - 1 : i - 1;
                g = ring[p] & mask[i];
                nx[i] = (i == int'(INV)) ? ~g : g;
            end
            ring = nx;
            taps.push_back(int'(ring[S-1]));
            if (taps[n-1] != taps[n]) edges++;
            if (taps[n-1] == 0 && taps[n] == 1) rises.push_back(n);
            if (rises.size() == 2) begin
                kind     = 2;
                period   = rises[1] - rises[0];
                len      = n;
                ring_end = ring;
                return;
            end
        end
        kind     = int'(ring[S-1]);
        period   = 0;
        len      = t_end;
        ring_end = ring;
    endfunction

    // One complete run: start, count RUN cycles, check result, hold under
    // backpressure while pulsing start, then handshake with start also high.
    task automatic do_run(input string tag, input logic seed, input logic [S-1:0] mask, input int tmo,
                          input int hold, input int e_kind, input int e_period, input int e_edges,
                          input int e_len, input logic [S-1:0] e_ring);
        int cyc;
        @(negedge clk);
        i_start    = 1'b1;
        i_seed     = seed;
        i_pin_mask = mask;
        i_timeout  = CW'(tmo);
        @(negedge clk);
        i_start = 1'b0;
        check({tag, "_busy_run"}, 32'(o_busy), 32'(1));
        cyc = 0;
        while (o_res_valid !== 1'b1 && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "_run_len"}, 32'(cyc), 32'(e_len));
        check({tag, "_kind"}, 32'(o_res_kind), 32'(e_kind));
        check({tag, "_period"}, 32'(o_res_period), 32'(e_period));
        check({tag, "_ring"}, 32'(o_ring_state), 32'(e_ring));
`ifdef LOOP_HIST_EN
        check({tag, "_edges"}, 32'(o_res_edges), 32'(e_edges));
`else
        if (e_edges < 0) $display("edges %0d", e_edges);
`endif
        for (int k = 0; k < hold; k++) begin
            i_start = ~i_start;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(o_res_valid), 32'(1));
            check({tag, "_hold_kind"}, 32'(o_res_kind), 32'(e_kind));
            check({tag, "_hold_period"}, 32'(o_res_period), 32'(e_period));
            check({tag, "_hold_ring"}, 32'(o_ring_state), 32'(e_ring));
        end
        i_start     = 1'b1;
        i_res_ready = 1'b1;
        @(negedge clk);
        i_start     = 1'b0;
        i_res_ready = 1'b0;
        check({tag, "_idle_after_ack"}, 32'({o_busy, o_res_valid}), 32'(0));
        @(negedge clk);
        check({tag, "_still_idle"}, 32'(o_busy), 32'(0));
        check({tag, "_ring_held"}, 32'(o_ring_state), 32'(e_ring));
    endtask

    initial begin
        int           kind;
        int           period;
        int           edges;
        int           len;
        logic [S-1:0] ring_end;
        logic [S-1:0] mask;
        logic         seed;
        int           tmo;

        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_seed      = 1'b0;
        i_pin_mask  = '0;
        i_timeout   = '0;
        i_res_ready = 1'b0;

        //            seed  mask     tmo kind per edg len
        vecs[0] = '{1'b1, 9'h1FF, 64, 2, 18, 4, 32};
        vecs[1] = '{1'b0, 9'h1FB, 40, 1,  0, 1, 40};
        vecs[2] = '{1'b1, 9'h1FF, 10, 0,  0, 1, 10};
        vecs[3] = '{1'b1, 9'h1FF,  0, 1,  0, 0,  1};
        vecs[4] = '{1'b0, 9'h1FF, 64, 2, 18, 3, 23};
        vecs[5] = '{1'b0, 9'h1FF,  1, 0,  0, 0,  1};
        vecs[6] = '{1'b1, 9'h1FF, 14, 1,  0, 2, 14};
        vecs[7] = '{1'b1, 9'h1FF, 32, 2, 18, 4, 32};
        vecs[8] = '{1'b1, 9'h1FF, 31, 0,  0, 3, 31};

        #3;
        check("reset_outputs", 32'({o_busy, o_res_valid, o_res_kind, o_res_period, o_ring_state}), 32'(0));
        check("reset_edges", 32'(o_res_edges), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table; first entry also exercises five cycles of backpressure
        for (int v = 0; v < 9; v++) begin
            model_run(vecs[v].seed, vecs[v].mask, vecs[v].tmo, kind, period, edges, len, ring_end);
            do_run($sformatf("vec%0d", v), vecs[v].seed, vecs[v].mask, vecs[v].tmo,
                   (v == 0) ? 5 : v % 3, vecs[v].kind, vecs[v].period, vecs[v].edges,
                   vecs[v].len, ring_end);
        end

        // Reset in the middle of a run, then the same run again
        @(negedge clk);
        i_start    = 1'b1;
        i_seed     = 1'b1;
        i_pin_mask = 9'h1FF;
        i_timeout  = CW'(64);
        @(negedge clk);
        i_start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", 32'({o_busy, o_res_valid, o_res_kind, o_res_period, o_ring_state}), 32'(0));
        check("midrun_reset_edges", 32'(o_res_edges), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_run(1'b1, 9'h1FF, 64, kind, period, edges, len, ring_end);
        do_run("after_reset", 1'b1, 9'h1FF, 64, 1, 2, 18, 4, 32, ring_end);

        // Randomized runs against the reference model
        for (int r = 0; r < 40; r++) begin
            seed = 1'($urandom_range(0, 1));
            mask = ($urandom_range(0, 1) == 0) ? 9'h1FF : S'($urandom);
            tmo  = int'($urandom_range(0, 100));
            model_run(seed, mask, tmo, kind, period, edges, len, ring_end);
            do_run($sformatf("rnd%0d", r), seed, mask, tmo, int'($urandom_range(0, 3)),
                   kind, period, edges, len, ring_end);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
